// File: rtl/smps_pkg.sv
// Shared definitions for the open-loop SMPS controller blocks.
package smps_pkg;

  // On-time width shared by the DPWM, the duty selector and the soft-start ramp.
  localparam int unsigned SMPS_TON_W = 11;

  // Soft-start ramp controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    TRACK = 2'd2
  } ss_state_t;

endpackage

// File: rtl/ss_tick_gen.sv
// Step-rate divider: pulses tick once every STEP_DIV cycles while running.
module ss_tick_gen #(
  parameter int unsigned STEP_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = (r_count == LAST);
  assign tick   = run && w_last;

  // Free-running 0..STEP_DIV-1 counter, parked at zero when stopped or cleared.
  always_ff @(posedge clk) begin
    if (rst || clear || !run) begin
      r_count <= '0;
    end else if (w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/soft_start_ramp.sv
// Slew-limited on-time generator feeding the DPWM during and after soft start.
module soft_start_ramp
  import smps_pkg::*;
#(
  parameter int unsigned TON_W     = SMPS_TON_W,
  parameter int unsigned STEP_DIV  = 1000,
  parameter int unsigned STEP      = 1,
  parameter int unsigned START_TON = 0,
  parameter int unsigned TON_MAX   = 2047
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [TON_W-1:0] i_ton_target,
  output logic [TON_W-1:0] o_ton,
  output logic             o_pwm_en,
  output logic             o_ramp_done
);

  localparam logic [TON_W-1:0] START_V = TON_W'(START_TON);
  localparam logic [TON_W-1:0] MAX_V   = TON_W'(TON_MAX);
  // A step wider than the on-time range always snaps, so saturating it at
  // 2**TON_W keeps the |d| <= STEP compare exact within TON_W+1 bits.
  localparam int unsigned      STEP_SAT = (STEP > (1 << TON_W)) ? (1 << TON_W) : STEP;
  localparam logic [TON_W:0]   STEP_V   = (TON_W + 1)'(STEP_SAT);

  ss_state_t        r_state;
  logic [TON_W-1:0] r_ton;
  logic             r_pwm_en;
  logic             r_ramp_done;

  ss_state_t        w_state_nxt;
  logic [TON_W-1:0] w_ton_nxt;
  logic             w_pwm_en_nxt;
  logic             w_ramp_done_nxt;

  logic             w_tick;
  logic             w_run;
  logic [TON_W-1:0] w_tgt;
  logic             w_up;
  logic [TON_W:0]   w_diff;
  logic             w_snap;
  logic [TON_W:0]   w_slewed;
  logic [TON_W-1:0] w_stepped;

  assign w_run = (r_state != IDLE);

  ss_tick_gen #(
    .STEP_DIV(STEP_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(!enable),
    .run  (w_run),
    .tick (w_tick)
  );

  // Effective target clamped to TON_MAX, and one slew step toward it.
  always_comb begin
    w_tgt     = (i_ton_target > MAX_V) ? MAX_V : i_ton_target;
    w_up      = ({1'b0, w_tgt} >= {1'b0, r_ton});
    w_diff    = w_up ? ({1'b0, w_tgt} - {1'b0, r_ton})
                     : ({1'b0, r_ton} - {1'b0, w_tgt});
    w_snap    = (w_diff <= STEP_V);
    // When not snapping, |d| > STEP so the result stays strictly between
    // r_ton and tgt; the top bit is always zero and truncation is exact.
    w_slewed  = w_up ? ({1'b0, r_ton} + STEP_V) : ({1'b0, r_ton} - STEP_V);
    w_stepped = w_snap ? w_tgt : w_slewed[TON_W-1:0];
  end

  // Next-state and next-output logic; a dropped enable wins over any tick.
  always_comb begin
    w_state_nxt     = r_state;
    w_ton_nxt       = r_ton;
    w_pwm_en_nxt    = r_pwm_en;
    w_ramp_done_nxt = r_ramp_done;
    if (!enable) begin
      w_state_nxt     = IDLE;
      w_ton_nxt       = START_V;
      w_pwm_en_nxt    = 1'b0;
      w_ramp_done_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt     = RAMP;
          w_ton_nxt       = START_V;
          w_pwm_en_nxt    = 1'b1;
          w_ramp_done_nxt = 1'b0;
        end
        RAMP: begin
          w_pwm_en_nxt = 1'b1;
          if (w_tick) begin
            w_ton_nxt = w_stepped;
            if (w_snap) begin
              w_state_nxt     = TRACK;
              w_ramp_done_nxt = 1'b1;
            end
          end
        end
        TRACK: begin
          w_pwm_en_nxt    = 1'b1;
          w_ramp_done_nxt = 1'b1;
          if (w_tick) begin
            w_ton_nxt = w_stepped;
          end
        end
        default: begin
          w_state_nxt     = IDLE;
          w_ton_nxt       = START_V;
          w_pwm_en_nxt    = 1'b0;
          w_ramp_done_nxt = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ton       <= START_V;
      r_pwm_en    <= 1'b0;
      r_ramp_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ton       <= w_ton_nxt;
      r_pwm_en    <= w_pwm_en_nxt;
      r_ramp_done <= w_ramp_done_nxt;
    end
  end

  assign o_ton       = r_ton;
  assign o_pwm_en    = r_pwm_en;
  assign o_ramp_done = r_ramp_done;

endmodule

// File: tb/tb_soft_start_ramp.sv
// Directed bench for soft_start_ramp: two instances with different step sizes.
module tb_soft_start_ramp;

  localparam int unsigned W = 11;

  logic         clk;
  logic         rst;
  logic         en_a;
  logic         en_b;
  logic [W-1:0] tgt_a;
  logic [W-1:0] tgt_b;
  logic [W-1:0] ton_a;
  logic [W-1:0] ton_b;
  logic         pwm_a;
  logic         pwm_b;
  logic         done_a;
  logic         done_b;

  int unsigned n_checks;
  int unsigned n_fail;

  // A: 4-cycle steps of 1 count.
  soft_start_ramp #(
    .TON_W    (W),
    .STEP_DIV (4),
    .STEP     (1),
    .START_TON(0),
    .TON_MAX  (2047)
  ) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .enable      (en_a),
    .i_ton_target(tgt_a),
    .o_ton       (ton_a),
    .o_pwm_en    (pwm_a),
    .o_ramp_done (done_a)
  );

  // B: 4-cycle steps of 3 counts, target clamped at 2000.
  soft_start_ramp #(
    .TON_W    (W),
    .STEP_DIV (4),
    .STEP     (3),
    .START_TON(0),
    .TON_MAX  (2000)
  ) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .enable      (en_b),
    .i_ton_target(tgt_b),
    .o_ton       (ton_b),
    .o_pwm_en    (pwm_b),
    .o_ramp_done (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned exp_b;
    int unsigned max_b;
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b1;
    en_a  = 1'b0;
    en_b  = 1'b0;
    tgt_a = '0;
    tgt_b = '0;
    cyc(2);
    chk("rst_ton_a", ton_a, 0);
    chk("rst_pwm_a", pwm_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_pwm_b", pwm_b, 0);
    rst = 1'b0;
    cyc(2);
    chk("idle_pwm_a", pwm_a, 0);

    // Ramp 0 -> 10 with STEP=1.
    tgt_a = 11'd10;
    en_a  = 1'b1;
    cyc(1);
    chk("en_pwm_a", pwm_a, 1);
    chk("en_ton_a", ton_a, 0);
    cyc(3);
    chk("first_step_latency", ton_a, 0);
    cyc(1);
    chk("ramp_a_1", ton_a, 1);
    chk("ramp_a_done_1", done_a, 0);
    for (int k = 2; k <= 10; k++) begin
      cyc(3);
      chk("ramp_a_hold", ton_a, k - 1);
      cyc(1);
      chk("ramp_a_step", ton_a, k);
      chk("ramp_a_done", done_a, (k == 10) ? 1 : 0);
    end

    // Re-slew down in TRACK.
    tgt_a = 11'd7;
    for (int k = 9; k >= 7; k--) begin
      cyc(4);
      chk("track_a_step", ton_a, k);
      chk("track_a_done", done_a, 1);
      chk("track_a_pwm", pwm_a, 1);
    end
    cyc(4);
    chk("track_a_settled", ton_a, 7);

    // Restart, then drop enable at ton=5 on a cycle where the tick is pending.
    en_a  = 1'b0;
    cyc(1);
    chk("drop_a_ton", ton_a, 0);
    chk("drop_a_done", done_a, 0);
    tgt_a = 11'd10;
    en_a  = 1'b1;
    cyc(1);
    cyc(20);
    chk("mid_a_ton5", ton_a, 5);
    cyc(3);
    en_a = 1'b0;
    cyc(1);
    chk("drop_prio_ton", ton_a, 0);
    chk("drop_prio_pwm", pwm_a, 0);
    chk("drop_prio_done", done_a, 0);
    en_a = 1'b1;
    cyc(1);
    chk("reen_pwm_a", pwm_a, 1);
    chk("reen_ton_a", ton_a, 0);
    cyc(3);
    chk("reen_hold_a", ton_a, 0);
    cyc(1);
    chk("reen_step_a", ton_a, 1);
    cyc(4);
    chk("pre_rst_ton_a", ton_a, 2);

    // Reset mid-ramp with enable still high.
    rst = 1'b1;
    cyc(1);
    chk("mid_rst_ton", ton_a, 0);
    chk("mid_rst_pwm", pwm_a, 0);
    chk("mid_rst_done", done_a, 0);
    rst = 1'b0;
    cyc(1);
    chk("post_rst_pwm", pwm_a, 1);
    chk("post_rst_ton", ton_a, 0);
    cyc(4);
    chk("post_rst_step", ton_a, 1);
    en_a = 1'b0;

    // STEP=3 toward 10: 3, 6, 9, 10.
    tgt_b = 11'd10;
    en_b  = 1'b1;
    cyc(1);
    chk("en_pwm_b", pwm_b, 1);
    cyc(4);
    chk("ramp_b_3", ton_b, 3);
    cyc(4);
    chk("ramp_b_6", ton_b, 6);
    cyc(4);
    chk("ramp_b_9", ton_b, 9);
    chk("ramp_b_done_9", done_b, 0);
    cyc(4);
    chk("ramp_b_10", ton_b, 10);
    chk("ramp_b_done_10", done_b, 1);
    cyc(4);
    chk("ramp_b_no_overshoot", ton_b, 10);

    // Target above TON_MAX: slews 10 -> 2000 and stops there.
    tgt_b = 11'd2047;
    exp_b = 10;
    max_b = 0;
    while (exp_b != 2000) begin
      exp_b = (2000 - exp_b <= 3) ? 2000 : exp_b + 3;
      cyc(4);
      if (ton_b > max_b) max_b = ton_b;
    end
    chk("clamp_b_final", ton_b, 2000);
    cyc(8);
    chk("clamp_b_hold", ton_b, 2000);
    chk("clamp_b_max", max_b, 2000);

    // Target equal to START_TON: first tick enters TRACK without moving.
    en_b  = 1'b0;
    cyc(1);
    chk("drop_b_ton", ton_b, 0);
    tgt_b = '0;
    en_b  = 1'b1;
    cyc(1);
    chk("zero_b_done_pre", done_b, 0);
    cyc(4);
    chk("zero_b_done", done_b, 1);
    chk("zero_b_ton", ton_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/soft_start_ramp.md
# soft_start_ramp

Slew-limited on-time generator placed between the duty selector and the DPWM core of the open-loop SMPS controller. When enabled, it raises the DPWM on-time from a start value toward the requested target in fixed steps at a programmable rate. This limits inrush current at power-up. After it reaches the target, it keeps tracking later target changes at the same slew rate. It drives the DPWM `i_ton` and `enable` inputs.

## Interface
- `TON_W`, 11: on-time width, matching the DPWM `i_ton`.
- `STEP_DIV`, 1000: clock cycles per ramp step. Must be at least 1.
- `STEP`, 1: on-time change per step, in counts. Must be at least 1.
- `START_TON`, 0: on-time applied when the ramp begins.
- `TON_MAX`, 2047: upper clamp applied to the target. Must be at least `START_TON`.

- `clk`  in  1  system clock. One clock domain only.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  converter run request, level-sensitive.
- `i_ton_target`  in  `TON_W`  requested on-time from the duty selector.
- `o_ton`  out  `TON_W`  slew-limited on-time, connected to DPWM `i_ton`.
- `o_pwm_en`  out  1  DPWM enable.
- `o_ramp_done`  out  1  high once the initial ramp has first reached the target.

## Operation
- All outputs are registered.
- Reset values: state IDLE, `o_ton`=`START_TON`, `o_pwm_en`=0, `o_ramp_done`=0, divider=0.
- Effective target `tgt` = min(`i_ton_target`, `TON_MAX`). It is sampled every cycle, so target changes take effect on the next step.
- Divider:
  - Runs only in RAMP and TRACK; held at 0 in IDLE.
  - Counts 0..`STEP_DIV`-1 and asserts `tick` when count = `STEP_DIV`-1, then wraps to 0.
- Step rule on `tick`, with d = `tgt` − `o_ton`:
  - If |d| ≤ `STEP`: `o_ton` ← `tgt`.
  - Else if d > 0: `o_ton` ← `o_ton` + `STEP`.
  - Else: `o_ton` ← `o_ton` − `STEP`.
  - Never overshoots, never wraps; the arithmetic uses `TON_W`+1 bits.
- States:
  - IDLE:
    - `o_pwm_en`=0, `o_ton`=`START_TON`, `o_ramp_done`=0.
    - `enable`=1 → RAMP.
  - RAMP:
    - `o_pwm_en`=1; step rule applies.
    - On the tick where the step rule assigns `o_ton` ← `tgt`: go to TRACK and set `o_ramp_done`=1 on the same edge.
  - TRACK:
    - `o_pwm_en`=1, `o_ramp_done`=1.
    - Step rule continues, so target changes are followed at the same slew rate.
    - `o_ramp_done` stays 1 even while re-slewing.
- `enable`=0 in any state → IDLE on the next edge:
  - `o_ton`=`START_TON`, `o_pwm_en`=0, `o_ramp_done`=0, divider cleared.
  - Takes priority over a simultaneous tick.
- Re-asserting `enable` after a drop always restarts a full ramp from `START_TON`.
- `rst` overrides everything, including mid-ramp.
- If `tgt` = `START_TON` at entry to RAMP, the first tick moves to TRACK with no change to `o_ton`.

## Timing
- `enable` sampled high at edge N:
  - `o_pwm_en`=1 and the state is RAMP after edge N.
  - First `o_ton` change occurs at edge N+`STEP_DIV`.
  - Subsequent changes occur every `STEP_DIV` cycles.
- Ramp duration = ceil(|`tgt`−`START_TON`| / `STEP`) × `STEP_DIV` cycles (a minimum of 1 step).
- `enable` sampled low at edge M: all outputs reach their IDLE values after edge M, a latency of 1 cycle.
- A target change is first visible at the next tick. There is no combinational path from any input to any output.

## Structure
- Shared package `smps_pkg` holds:
  - `TON_W` default constant, shared with DPWM and the duty selector.
  - State enum `ss_state_t` {IDLE, RAMP, TRACK}.
- One sub-module, `ss_tick_gen`: the parameterised `STEP_DIV` divider with `clear` and `run` inputs and a `tick` output.
- The slew arithmetic and the state machine live in the top module.

## Test plan
- `STEP_DIV`=4, `STEP`=1, `START_TON`=0, target 10; raise `enable` → `o_pwm_en` goes to 1 one edge later. `o_ton` then steps 1..10 every 4 cycles. `o_ramp_done` rises on the same edge that `o_ton`=10, 40 cycles after `o_pwm_en`.
- `STEP`=3, target 10 → `o_ton` sequence 3, 6, 9, 10; no overshoot.
- In TRACK, change target from 10 to 7 → `o_ton` sequence 9, 8, 7 at 4-cycle spacing; `o_ramp_done` stays 1.
- Drop `enable` while `o_ton`=5, mid-ramp → next edge gives `o_ton`=0, `o_pwm_en`=0, `o_ramp_done`=0. Re-enable → the ramp restarts from 0.
- `TON_MAX`=2000, target 2047 → the ramp ends at 2000 and never exceeds it.
- Assert `rst` during RAMP while `enable` stays high → all outputs take their reset values. The ramp then restarts from `START_TON` on the first edge after `rst` is released.
